// File: rtl/birth_digit_scanner_pkg.sv
// Shared definitions for the birth-date digit scanner: FSM state encoding,
// default digit count and seven-segment patterns ({g,f,e,d,c,b,a}, active-high).
// Optional feature macro used by this slice: SEG_DECODE_EN.
package birth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int DEF_NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/birth_digit_scanner_if.sv
// Bundle between the scanner, its digit lookup and the display stage.
// The slave modport is the scanner's view; master is the surrounding system.
// The seg signal exists only when SEG_DECODE_EN is defined.
interface birth_digit_scanner_if;

  logic       start;
  logic       mode;
  logic       stop;
  logic [2:0] idx;
  logic [3:0] digit_in;
  logic [3:0] digit_q;
  logic       digit_valid;
  logic       busy;
  logic       done;
`ifdef SEG_DECODE_EN
  logic [6:0] seg;
`endif

  modport slave (
`ifdef SEG_DECODE_EN
    output seg,
`endif
    input  start,
    input  mode,
    input  stop,
    input  digit_in,
    output idx,
    output digit_q,
    output digit_valid,
    output busy,
    output done
  );

  modport master (
`ifdef SEG_DECODE_EN
    input  seg,
`endif
    output start,
    output mode,
    output stop,
    output digit_in,
    input  idx,
    input  digit_q,
    input  digit_valid,
    input  busy,
    input  done
  );

endinterface

// File: rtl/birth_digit_scanner_seg7.sv
// Combinational 4-bit to seven-segment decoder; codes above 9 blank the display.
// Only compiled when SEG_DECODE_EN is defined.
`ifdef SEG_DECODE_EN
module seg7_decode
  import birth_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pattern lookup for decimal digits, blank otherwise.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`endif

// File: rtl/birth_digit_scanner.sv
// Digit sequencer: walks the lookup index, latches each returned digit and
// holds it for TICK_DIV cycles, single pass or continuous loop. stop aborts
// from any state. Optional seven-segment output under SEG_DECODE_EN.
module birth_digit_scanner
  import birth_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  birth_digit_scanner_if.slave   bus
);

  localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TICK_DIV - 1);
  localparam logic [2:0]      LAST_IDX = 3'(NUM_DIGITS - 1);

  scan_state_t      state_r, state_nxt_s;
  logic [2:0]       idx_r, idx_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [3:0]       digit_q_r, digit_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             done_r, done_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             mode_r, mode_nxt_s;
  logic             latch_s;

  // Next-state and next-output decode; stop overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    digit_nxt_s = digit_q_r;
    mode_nxt_s  = mode_r;
    valid_nxt_s = 1'b0;
    done_nxt_s  = 1'b0;
    latch_s     = 1'b0;
    if (bus.stop) begin
      state_nxt_s = IDLE;
      idx_nxt_s   = 3'd0;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          idx_nxt_s = 3'd0;
          if (bus.start) begin
            mode_nxt_s  = bus.mode;
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        FETCH: begin
          digit_nxt_s = bus.digit_in;
          valid_nxt_s = 1'b1;
          latch_s     = 1'b1;
          cnt_nxt_s   = CNT_LOAD;
          state_nxt_s = SHOW;
        end
        SHOW: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end else if (idx_r < LAST_IDX) begin
            idx_nxt_s   = idx_r + 3'd1;
            state_nxt_s = FETCH;
          end else if (mode_r) begin
            idx_nxt_s   = 3'd0;
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          idx_nxt_s   = 3'd0;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= 3'd0;
      cnt_r     <= CNT_ZERO;
      digit_q_r <= 4'd0;
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      mode_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      cnt_r     <= cnt_nxt_s;
      digit_q_r <= digit_nxt_s;
      valid_r   <= valid_nxt_s;
      done_r    <= done_nxt_s;
      busy_r    <= busy_nxt_s;
      mode_r    <= mode_nxt_s;
    end
  end

  assign bus.idx         = idx_r;
  assign bus.digit_q     = digit_q_r;
  assign bus.digit_valid = valid_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

`ifdef SEG_DECODE_EN
  logic [6:0] seg_r;
  logic [6:0] seg_dec_s;

  seg7_decode u_seg7_decode (
    .digit (bus.digit_in),
    .seg   (seg_dec_s)
  );

  // Segment pattern register, refreshed together with digit_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= SEG_BLANK;
    end else if (latch_s) begin
      seg_r <= seg_dec_s;
    end else begin
      seg_r <= seg_r;
    end
  end

  assign bus.seg = seg_r;
`endif

endmodule

// File: tb/tb_birth_digit_scanner.sv
// Directed bench for birth_digit_scanner with a birth-date lookup model
// (1,9,9,7,0,7,2,8). Seg checks are included when SEG_DECODE_EN is defined.
module tb_birth_digit_scanner;

  logic clk;
  logic rst_n;
  logic force_c;
  int   n_vec;
  int   n_err;
  int   k;
  int   done_seen;
  int   cyc;

  logic [3:0] exp_dig [8];
  logic [6:0] exp_seg [8];

  birth_digit_scanner_if bus ();

  birth_digit_scanner #(.TICK_DIV(4), .NUM_DIGITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Lookup model: zero-latency digit for the index.
  function automatic logic [3:0] lut(input logic [2:0] i);
    case (i)
      3'd0: lut = 4'd1;
      3'd1: lut = 4'd9;
      3'd2: lut = 4'd9;
      3'd3: lut = 4'd7;
      3'd4: lut = 4'd0;
      3'd5: lut = 4'd7;
      3'd6: lut = 4'd2;
      3'd7: lut = 4'd8;
      default: lut = 4'hF;
    endcase
  endfunction

  assign bus.digit_in = force_c ? 4'hC : lut(bus.idx);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_dig = '{4'd1, 4'd9, 4'd9, 4'd7, 4'd0, 4'd7, 4'd2, 4'd8};
    exp_seg = '{7'h06, 7'h6F, 7'h6F, 7'h07, 7'h3F, 7'h07, 7'h5B, 7'h7F};
    rst_n     = 1'b0;
    force_c   = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.stop  = 1'b0;

    // Reset values
    repeat (3) tick;
    chk_eq("rst_idx",   32'(bus.idx), 32'd0);
    chk_eq("rst_digit", 32'(bus.digit_q), 32'd0);
    chk_eq("rst_valid", 32'(bus.digit_valid), 32'd0);
    chk_eq("rst_busy",  32'(bus.busy), 32'd0);
    chk_eq("rst_done",  32'(bus.done), 32'd0);
`ifdef SEG_DECODE_EN
    chk_eq("rst_seg",   32'(bus.seg), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (4) begin
      tick;
      chk_eq("idle_valid", 32'(bus.digit_valid), 32'd0);
    end
    chk_eq("idle_busy", 32'(bus.busy), 32'd0);

    // Single pass
    bus.mode  = 1'b0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk_eq("sp_busy_rise", 32'(bus.busy), 32'd1);
    chk_eq("sp_idx0",      32'(bus.idx), 32'd0);
    chk_eq("sp_no_valid",  32'(bus.digit_valid), 32'd0);
    k = 0;
    done_seen = 0;
    for (int c = 2; c <= 45; c++) begin
      tick;
      if (bus.digit_valid) begin
        if (k < 8) begin
          chk_eq("sp_digit", 32'(bus.digit_q), 32'(exp_dig[k]));
          chk_eq("sp_when",  32'(c), 32'(2 + 5 * k));
`ifdef SEG_DECODE_EN
          chk_eq("sp_seg",   32'(bus.seg), 32'(exp_seg[k]));
`endif
        end
        k++;
      end
      if (bus.done) begin
        done_seen++;
        chk_eq("sp_done_at",   32'(c), 32'd41);
        chk_eq("sp_busy_fall", 32'(bus.busy), 32'd0);
      end
      if (c == 40) chk_eq("sp_busy_hold", 32'(bus.busy), 32'd1);
    end
    chk_eq("sp_count",    32'(k), 32'd8);
    chk_eq("sp_done_cnt", 32'(done_seen), 32'd1);

    // Continuous loop, 20 digits; mode toggled mid-pass must not matter
    bus.mode  = 1'b1;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    k = 0;
    done_seen = 0;
    for (int c = 2; c <= 99; c++) begin
      tick;
      if (bus.digit_valid) begin
        if (k < 20) begin
          chk_eq("lp_digit", 32'(bus.digit_q), 32'(exp_dig[k % 8]));
          chk_eq("lp_idx",   32'(bus.idx), 32'(k % 8));
          chk_eq("lp_when",  32'(c), 32'(2 + 5 * k));
        end
        k++;
      end
      if (bus.done) done_seen++;
    end
    chk_eq("lp_count",   32'(k), 32'd20);
    chk_eq("lp_no_done", 32'(done_seen), 32'd0);
    chk_eq("lp_busy",    32'(bus.busy), 32'd1);
    bus.stop = 1'b1;
    tick;
    bus.stop = 1'b0;
    chk_eq("lp_stop_busy", 32'(bus.busy), 32'd0);

    // Stop during SHOW of digit 3, with start raised at the same time
    bus.mode  = 1'b0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    k = 0;
    cyc = 1;
    while (k < 4 && cyc < 60) begin
      tick;
      cyc++;
      if (bus.digit_valid) k++;
    end
    chk_eq("st_reach", 32'(k), 32'd4);
    tick;
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    tick;
    chk_eq("st_busy",  32'(bus.busy), 32'd0);
    chk_eq("st_idx",   32'(bus.idx), 32'd0);
    chk_eq("st_done",  32'(bus.done), 32'd0);
    chk_eq("st_digit", 32'(bus.digit_q), 32'd7);
    tick;
    chk_eq("st_start_ignored", 32'(bus.busy), 32'd0);
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    done_seen = 0;
    k = 0;
    repeat (8) begin
      tick;
      if (bus.done) done_seen++;
      if (bus.digit_valid) k++;
    end
    chk_eq("st_quiet_done",  32'(done_seen), 32'd0);
    chk_eq("st_quiet_valid", 32'(k), 32'd0);
    chk_eq("st_hold_digit",  32'(bus.digit_q), 32'd7);

    // Asynchronous reset during FETCH of index 1
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (5) tick;
    chk_eq("ar_pre_idx",   32'(bus.idx), 32'd1);
    chk_eq("ar_pre_busy",  32'(bus.busy), 32'd1);
    chk_eq("ar_pre_digit", 32'(bus.digit_q), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("ar_idx",   32'(bus.idx), 32'd0);
    chk_eq("ar_busy",  32'(bus.busy), 32'd0);
    chk_eq("ar_digit", 32'(bus.digit_q), 32'd0);
    chk_eq("ar_valid", 32'(bus.digit_valid), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk_eq("ar_stay_idle", 32'(bus.busy), 32'd0);

    // Out-of-range digit is latched unchanged; segments blank
    force_c   = 1'b1;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    chk_eq("oor_valid", 32'(bus.digit_valid), 32'd1);
    chk_eq("oor_digit", 32'(bus.digit_q), 32'hC);
`ifdef SEG_DECODE_EN
    chk_eq("oor_seg",   32'(bus.seg), 32'h00);
`endif
    bus.stop = 1'b1;
    tick;
    bus.stop = 1'b0;
    force_c  = 1'b0;
    chk_eq("oor_stop_busy", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
